// File: rtl/mb_io_pkg.sv
// Shared constants for the MicroBlaze MCS IO bus controller: FSM state
// encoding, fixed response data words and the slave-select range helper.
package mb_io_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [31:0] ERR_DATA     = 32'h0000_0000;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  localparam int MAX_SLAVES = 4;

  function automatic logic sel_in_range(input logic [1:0] sel, input int num_slaves);
    return int'({30'd0, sel}) < num_slaves;
  endfunction

endpackage

// File: rtl/mb_io_timeout.sv
// WAIT-state watchdog: 16-bit cycle counter plus a saturating count of
// transactions that were forced to complete by the watchdog.
module mb_io_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wait_enter,
  input  logic       in_wait,
  input  logic       timeout_taken,
  output logic       expired,
  output logic [7:0] timeout_count
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    if (wait_enter) begin
      cnt_d = '0;
    end else if (in_wait) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (timeout_taken && (tmo_cnt_q != 8'hFF)) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      tmo_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign expired       = in_wait && (cnt_q == LIMIT);
  assign timeout_count = tmo_cnt_q;

endmodule

// File: rtl/mb_io_bus_ctrl.sv
// MCS IO bus to NUM_SLAVES slave decoder with a single outstanding transaction.
// Define MB_IO_TIMEOUT_EN to add the WAIT-state watchdog (mb_io_timeout).
module mb_io_bus_ctrl
  import mb_io_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     IO_Addr_Strobe,
  input  logic                     IO_Read_Strobe,
  input  logic                     IO_Write_Strobe,
  input  logic [31:0]              IO_Address,
  input  logic [3:0]               IO_Byte_Enable,
  input  logic [31:0]              IO_Write_Data,
  output logic [31:0]              IO_Read_Data,
  output logic                     IO_Ready,
  output logic [NUM_SLAVES-1:0]    s_addr_strobe,
  output logic                     s_read_strobe,
  output logic                     s_write_strobe,
  output logic [31:0]              s_address,
  output logic [3:0]               s_byte_enable,
  output logic [31:0]              s_write_data,
  input  logic [32*NUM_SLAVES-1:0] s_read_data,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  output logic                     busy,
  output logic [7:0]               timeout_count
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > MAX_SLAVES) begin : g_bad_num_slaves
    $error("mb_io_bus_ctrl: NUM_SLAVES must be 1..4");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mb_io_bus_ctrl: TIMEOUT_CYCLES must be 1..65535");
  end

  logic [1:0]  state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  sel_in;
  logic        sel_ok;
  logic        timeout_hit;
  logic [3:0]  strobe_all;
  logic [3:0]  slave_ready;
  logic [31:0] slave_rdata [MAX_SLAVES];

  assign sel_in = IO_Address[SEL_LSB+1:SEL_LSB];
  assign sel_ok = sel_in_range(sel_in, NUM_SLAVES);

  // Pad the slave bus to four entries so the 2-bit select never indexes out of range.
  for (genvar i = 0; i < MAX_SLAVES; i++) begin : g_slave
    if (i < NUM_SLAVES) begin : g_used
      assign slave_ready[i] = s_ready[i];
      assign slave_rdata[i] = s_read_data[32*i +: 32];
    end else begin : g_unused
      assign slave_ready[i] = 1'b0;
      assign slave_rdata[i] = '0;
    end
  end

  assign s_read_strobe  = IO_Read_Strobe;
  assign s_write_strobe = IO_Write_Strobe;
  assign s_address      = IO_Address;
  assign s_byte_enable  = IO_Byte_Enable;
  assign s_write_data   = IO_Write_Data;

  always_comb begin
    strobe_all = '0;
    if (!reset && IO_Addr_Strobe && (state_q == ST_IDLE) && sel_ok) begin
      strobe_all[sel_in] = 1'b1;
    end
  end
  assign s_addr_strobe = strobe_all[NUM_SLAVES-1:0];

  // The selected slave's ready wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (IO_Addr_Strobe) begin
          sel_d = sel_in;
          if (sel_ok) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RESP;
            data_d  = ERR_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (slave_ready[sel_q]) begin
          state_d = ST_RESP;
          data_d  = slave_rdata[sel_q];
        end else if (timeout_hit) begin
          state_d = ST_RESP;
          data_d  = TIMEOUT_DATA;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign IO_Ready     = (state_q == ST_RESP) && !reset;
  assign IO_Read_Data = IO_Ready ? data_q : '0;
  assign busy         = (state_q != ST_IDLE);

`ifdef MB_IO_TIMEOUT_EN
  logic wait_enter;
  logic timeout_taken;

  assign wait_enter    = (state_q == ST_IDLE) && IO_Addr_Strobe && sel_ok;
  assign timeout_taken = (state_q == ST_WAIT) && !slave_ready[sel_q] && timeout_hit;

  mb_io_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk           (clk),
    .reset         (reset),
    .wait_enter    (wait_enter),
    .in_wait       (state_q == ST_WAIT),
    .timeout_taken (timeout_taken),
    .expired       (timeout_hit),
    .timeout_count (timeout_count)
  );
`else
  assign timeout_hit   = 1'b0;
  assign timeout_count = 8'd0;
`endif

endmodule

// File: tb/tb_mb_io_bus_ctrl.sv
// Self-checking bench for mb_io_bus_ctrl: a 4-slave and a 2-slave instance
// share one MCS request stream; expectations come from latency/data rules.
module tb_mb_io_bus_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         io_as = 1'b0, io_rs = 1'b0, io_ws = 1'b0;
  logic [31:0]  io_addr = '0, io_wd = '0;
  logic [3:0]   io_be = '0;
  logic [127:0] s_rd = '0;
  logic [3:0]   s_rdy = '0;

  logic [31:0] rdata4, rdata2, sa4, swd4, sa2, swd2;
  logic        rdy4, rdy2, srs4, sws4, srs2, sws2, busy4, busy2;
  logic [3:0]  as4, sbe4, sbe2;
  logic [1:0]  as2;
  logic [7:0]  tc4, tc2;

  int total = 0;
  int bad = 0;

  // Observations of the most recent transaction, filled by run_txn.
  int          o_lat4, o_lat2, o_pulses4, o_pulses2, o_leak;
  logic [31:0] o_data4, o_data2, o_addr, o_wd;
  logic [3:0]  o_as4, o_later_as, o_be;
  logic [1:0]  o_as2;
  logic        o_busy_c1, o_rs, o_ws;

  always #5 clk = ~clk;

  mb_io_bus_ctrl #(.NUM_SLAVES(4), .SEL_LSB(6), .TIMEOUT_CYCLES(8)) dut4 (
    .clk(clk), .reset(reset), .IO_Addr_Strobe(io_as), .IO_Read_Strobe(io_rs),
    .IO_Write_Strobe(io_ws), .IO_Address(io_addr), .IO_Byte_Enable(io_be),
    .IO_Write_Data(io_wd), .IO_Read_Data(rdata4), .IO_Ready(rdy4),
    .s_addr_strobe(as4), .s_read_strobe(srs4), .s_write_strobe(sws4),
    .s_address(sa4), .s_byte_enable(sbe4), .s_write_data(swd4),
    .s_read_data(s_rd), .s_ready(s_rdy), .busy(busy4), .timeout_count(tc4)
  );

  mb_io_bus_ctrl #(.NUM_SLAVES(2), .SEL_LSB(6), .TIMEOUT_CYCLES(8)) dut2 (
    .clk(clk), .reset(reset), .IO_Addr_Strobe(io_as), .IO_Read_Strobe(io_rs),
    .IO_Write_Strobe(io_ws), .IO_Address(io_addr), .IO_Byte_Enable(io_be),
    .IO_Write_Data(io_wd), .IO_Read_Data(rdata2), .IO_Ready(rdy2),
    .s_addr_strobe(as2), .s_read_strobe(srs2), .s_write_strobe(sws2),
    .s_address(sa2), .s_byte_enable(sbe2), .s_write_data(swd2),
    .s_read_data(s_rd[63:0]), .s_ready(s_rdy[1:0]), .busy(busy2), .timeout_count(tc2)
  );

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; io_as = 1'b0; s_rdy = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Strobe in cycle 0, the selected slave readies in cycle 'delay' (0 = never).
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input int delay, input logic [31:0] rd,
                         input logic [3:0] wrong_rdy, input logic noise, input int window);
    logic [1:0] sel;
    sel = addr[7:6];
    o_lat4 = 0; o_lat2 = 0; o_pulses4 = 0; o_pulses2 = 0; o_leak = 0;
    o_data4 = '0; o_data2 = '0; o_later_as = '0; o_busy_c1 = 1'b0;
    @(negedge clk);
    io_as = 1'b1; io_rs = !we; io_ws = we; io_addr = addr; io_be = be; io_wd = wd; s_rdy = '0;
    for (int k = 0; k < 4; k++) s_rd[32*k +: 32] = $urandom;
    #1;
    o_as4 = as4; o_as2 = as2; o_addr = sa4; o_be = sbe4; o_wd = swd4; o_rs = srs4; o_ws = sws4;
    if (rdy4) o_pulses4++;
    if (rdy2) o_pulses2++;
    for (int c = 1; c <= window; c++) begin
      @(negedge clk);
      io_as = noise && (sel < 2'd2) && (c <= delay) && ($urandom_range(0, 1) == 1);
      s_rdy = wrong_rdy & ~(4'b0001 << sel);
      for (int k = 0; k < 4; k++) s_rd[32*k +: 32] = $urandom;
      if (c == delay) begin
        s_rdy[sel] = 1'b1;
        s_rd[32*sel +: 32] = rd;
      end
      #1;
      o_later_as = o_later_as | as4 | {2'b00, as2};
      if (c == 1) o_busy_c1 = busy4;
      if (rdy4) begin
        o_pulses4++;
        if (o_lat4 == 0) begin o_lat4 = c; o_data4 = rdata4; end
      end else if (rdata4 !== 32'h0) o_leak++;
      if (rdy2) begin
        o_pulses2++;
        if (o_lat2 == 0) begin o_lat2 = c; o_data2 = rdata2; end
      end else if (rdata2 !== 32'h0) o_leak++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; io_as = 1'b1; io_addr = 32'h0000_0040;
    #1;
    total++; if (as4 !== 4'b0000) begin bad++; $display("[TB] FAIL reset_strobe4 got=%b exp=0000", as4); end
    total++; if (as2 !== 2'b00) begin bad++; $display("[TB] FAIL reset_strobe2 got=%b exp=00", as2); end
    @(negedge clk);
    io_as = 1'b0;
    #1;
    total++; if (rdy4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=0", rdy4); end
    total++; if (rdata4 !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h exp=0", rdata4); end
    total++; if (busy4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy4); end
    total++; if (tc4 !== 8'd0) begin bad++; $display("[TB] FAIL reset_tcount got=%0d exp=0", tc4); end
    reset = 1'b0;
  endtask

  task automatic test_read_sel1();
    run_txn(32'h0000_0040, 1'b0, 4'hF, 32'h0, 1, 32'h1234_5678, 4'h0, 1'b0, 3);
    total++; if (o_as4 !== 4'b0010) begin bad++; $display("[TB] FAIL read1_strobe got=%b exp=0010", o_as4); end
    total++; if (o_rs !== 1'b1) begin bad++; $display("[TB] FAIL read1_rstrobe got=%b exp=1", o_rs); end
    total++; if (o_lat4 != 2) begin bad++; $display("[TB] FAIL read1_latency got=%0d exp=2", o_lat4); end
    total++; if (o_data4 !== 32'h1234_5678) begin bad++; $display("[TB] FAIL read1_data got=%h exp=12345678", o_data4); end
    total++; if (o_pulses4 != 1) begin bad++; $display("[TB] FAIL read1_pulses got=%0d exp=1", o_pulses4); end
    total++; if (o_busy_c1 !== 1'b1) begin bad++; $display("[TB] FAIL read1_busy got=%b exp=1", o_busy_c1); end
  endtask

  task automatic test_write_sel3();
    run_txn(32'h0000_00C0, 1'b1, 4'b0011, 32'hA5A5_A5A5, 3, 32'h0BAD_F00D, 4'h0, 1'b0, 5);
    total++; if (o_addr !== 32'h0000_00C0) begin bad++; $display("[TB] FAIL write3_addr got=%h exp=000000c0", o_addr); end
    total++; if (o_be !== 4'b0011) begin bad++; $display("[TB] FAIL write3_be got=%b exp=0011", o_be); end
    total++; if (o_wd !== 32'hA5A5_A5A5) begin bad++; $display("[TB] FAIL write3_wdata got=%h exp=a5a5a5a5", o_wd); end
    total++; if (o_ws !== 1'b1 || o_rs !== 1'b0) begin bad++; $display("[TB] FAIL write3_strobes got=%b%b exp=10", o_ws, o_rs); end
    total++; if (o_as4 !== 4'b1000) begin bad++; $display("[TB] FAIL write3_strobe got=%b exp=1000", o_as4); end
    total++; if (o_lat4 != 4) begin bad++; $display("[TB] FAIL write3_latency got=%0d exp=4", o_lat4); end
    total++; if (o_as2 !== 2'b00) begin bad++; $display("[TB] FAIL write3_dut2_strobe got=%b exp=00", o_as2); end
  endtask

  task automatic test_invalid_sel();
    run_txn(32'h0000_0080, 1'b0, 4'hF, 32'h0, 2, 32'h5555_AAAA, 4'h0, 1'b0, 4);
    total++; if (o_as2 !== 2'b00) begin bad++; $display("[TB] FAIL inval_strobe got=%b exp=00", o_as2); end
    total++; if (o_lat2 != 1) begin bad++; $display("[TB] FAIL inval_latency got=%0d exp=1", o_lat2); end
    total++; if (o_data2 !== 32'h0) begin bad++; $display("[TB] FAIL inval_data got=%h exp=0", o_data2); end
    total++; if (o_pulses2 != 1) begin bad++; $display("[TB] FAIL inval_pulses got=%0d exp=1", o_pulses2); end
    total++; if (o_as4 !== 4'b0100) begin bad++; $display("[TB] FAIL inval_dut4_strobe got=%b exp=0100", o_as4); end
    total++; if (o_data4 !== 32'h5555_AAAA) begin bad++; $display("[TB] FAIL inval_dut4_data got=%h exp=5555aaaa", o_data4); end
  endtask

  task automatic test_random();
    logic [1:0]  sel;
    logic [31:0] addr, rd, exp_d2;
    logic [1:0]  exp_as2;
    int          d, exp_lat2;
    for (int i = 0; i < 20; i++) begin
      sel = 2'($urandom_range(0, 3));
      d = $urandom_range(1, 6);
      rd = $urandom;
      addr = $urandom;
      addr[7:6] = sel;
      run_txn(addr, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, d, rd, 4'($urandom), 1'b1, d + 2);
      exp_lat2 = (sel < 2'd2) ? d + 1 : 1;
      exp_d2   = (sel < 2'd2) ? rd : 32'h0;
      exp_as2  = (sel < 2'd2) ? (2'b01 << sel) : 2'b00;
      total++; if (o_as4 !== (4'b0001 << sel)) begin bad++; $display("[TB] FAIL rand_strobe4 i=%0d got=%b exp=%b", i, o_as4, 4'b0001 << sel); end
      total++; if (o_lat4 != d + 1) begin bad++; $display("[TB] FAIL rand_lat4 i=%0d got=%0d exp=%0d", i, o_lat4, d + 1); end
      total++; if (o_data4 !== rd) begin bad++; $display("[TB] FAIL rand_data4 i=%0d got=%h exp=%h", i, o_data4, rd); end
      total++; if (o_pulses4 != 1) begin bad++; $display("[TB] FAIL rand_pulses4 i=%0d got=%0d exp=1", i, o_pulses4); end
      total++; if (o_as2 !== exp_as2) begin bad++; $display("[TB] FAIL rand_strobe2 i=%0d got=%b exp=%b", i, o_as2, exp_as2); end
      total++; if (o_lat2 != exp_lat2) begin bad++; $display("[TB] FAIL rand_lat2 i=%0d got=%0d exp=%0d", i, o_lat2, exp_lat2); end
      total++; if (o_data2 !== exp_d2) begin bad++; $display("[TB] FAIL rand_data2 i=%0d got=%h exp=%h", i, o_data2, exp_d2); end
      total++; if (o_later_as !== 4'b0000) begin bad++; $display("[TB] FAIL rand_busy_strobe i=%0d got=%b exp=0000", i, o_later_as); end
      total++; if (o_leak != 0) begin bad++; $display("[TB] FAIL rand_rdata_idle i=%0d got=%0d exp=0", i, o_leak); end
    end
  endtask

  task automatic test_wrong_ready_reset();
    run_txn(32'h0000_0080, 1'b0, 4'hF, 32'h0, 0, 32'h0, 4'b0011, 1'b0, 6);
    total++; if (o_pulses4 != 0) begin bad++; $display("[TB] FAIL wrongrdy_pulses got=%0d exp=0", o_pulses4); end
    total++; if (busy4 !== 1'b1) begin bad++; $display("[TB] FAIL wrongrdy_busy got=%b exp=1", busy4); end
    @(negedge clk);
    reset = 1'b1; io_as = 1'b1; s_rdy = 4'b0100;
    #1;
    total++; if (rdy4 !== 1'b0) begin bad++; $display("[TB] FAIL midreset_ready got=%b exp=0", rdy4); end
    total++; if (as4 !== 4'b0000) begin bad++; $display("[TB] FAIL midreset_strobe got=%b exp=0000", as4); end
    @(negedge clk);
    reset = 1'b0; io_as = 1'b0; s_rdy = '0;
    #1;
    total++; if (busy4 !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy4); end
    total++; if (rdy4 !== 1'b0) begin bad++; $display("[TB] FAIL midreset_ready_after got=%b exp=0", rdy4); end
    @(negedge clk);
    #1;
    total++; if (rdy4 !== 1'b0) begin bad++; $display("[TB] FAIL midreset_late_ready got=%b exp=0", rdy4); end
  endtask

`ifdef MB_IO_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rd;
    apply_reset();
    run_txn(32'h0000_0040, 1'b0, 4'hF, 32'h0, 0, 32'h0, 4'h0, 1'b0, 10);
    total++; if (o_lat4 != 9) begin bad++; $display("[TB] FAIL tmo_latency got=%0d exp=9", o_lat4); end
    total++; if (o_data4 !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL tmo_data got=%h exp=deadbeef", o_data4); end
    total++; if (tc4 !== 8'd1) begin bad++; $display("[TB] FAIL tmo_count got=%0d exp=1", tc4); end
    rd = $urandom;
    run_txn(32'h0000_0040, 1'b0, 4'hF, 32'h0, 8, rd, 4'h0, 1'b0, 10);
    total++; if (o_data4 !== rd) begin bad++; $display("[TB] FAIL tmo_priority_data got=%h exp=%h", o_data4, rd); end
    total++; if (tc4 !== 8'd1) begin bad++; $display("[TB] FAIL tmo_priority_count got=%0d exp=1", tc4); end
    for (int i = 0; i < 299; i++) begin
      run_txn(32'h0000_0040, 1'b0, 4'hF, 32'h0, 0, 32'h0, 4'h0, 1'b0, 10);
    end
    total++; if (tc4 !== 8'd255) begin bad++; $display("[TB] FAIL tmo_saturate4 got=%0d exp=255", tc4); end
    total++; if (tc2 !== 8'd255) begin bad++; $display("[TB] FAIL tmo_saturate2 got=%0d exp=255", tc2); end
  endtask
`else
  task automatic test_no_timeout();
    apply_reset();
    run_txn(32'h0000_0040, 1'b0, 4'hF, 32'h0, 0, 32'h0, 4'h0, 1'b0, 40);
    total++; if (o_pulses4 != 0) begin bad++; $display("[TB] FAIL notmo_pulses got=%0d exp=0", o_pulses4); end
    total++; if (busy4 !== 1'b1) begin bad++; $display("[TB] FAIL notmo_busy got=%b exp=1", busy4); end
    total++; if (tc4 !== 8'd0) begin bad++; $display("[TB] FAIL notmo_count got=%0d exp=0", tc4); end
    apply_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_read_sel1();
    test_write_sel3();
    test_invalid_sel();
    test_random();
    test_wrong_ready_reset();
`ifdef MB_IO_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
